// File: rtl/genshin_uart_pkg.sv
// rtl/genshin_uart_pkg.sv - shared types and constants for the UART transmit arbiter
package genshin_uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic OWNER_MANUAL = 1'b0;
  localparam logic OWNER_AUTO   = 1'b1;

  localparam logic [7:0] DEFAULT_IDLE_BYTE = 8'h00;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - source request/ack and UART byte path bundle
interface uart_tx_arbiter_if #(
  parameter int unsigned DATA_W = 8
);
  logic              req_m;
  logic [DATA_W-1:0] bits_m;
  logic              ack_m;
  logic              req_a;
  logic [DATA_W-1:0] bits_a;
  logic              ack_a;
  logic [DATA_W-1:0] tx_bits;
  logic              tx_ready;
  logic              busy;
  logic              owner;
  logic              timeout_err;

  modport master (
    output req_m, bits_m, req_a, bits_a, tx_ready,
    input  ack_m, ack_a, tx_bits, busy, owner, timeout_err
  );

  modport slave (
    input  req_m, bits_m, req_a, bits_a, tx_ready,
    output ack_m, ack_a, tx_bits, busy, owner, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter_rr2.sv
// rtl/uart_tx_arbiter_rr2.sv - combinational two-way round-robin pick
module tx_arb_rr2
  import genshin_uart_pkg::*;
(
  input  logic req_m,
  input  logic req_a,
  input  logic owner,
  output logic grant_valid,
  output logic grant_id
);

  // A lone requester wins; on a tie the source that did not own the last grant wins.
  always_comb begin
    grant_valid = req_m | req_a;
    grant_id    = OWNER_MANUAL;
    if (req_m && req_a) begin
      grant_id = ~owner;
    end else if (req_a) begin
      grant_id = OWNER_AUTO;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - one-byte-per-grant UART transmit arbiter; optional send timeout via UART_TX_TIMEOUT_EN
module uart_tx_arbiter
  import genshin_uart_pkg::*;
#(
  parameter int unsigned       DATA_W         = 8,
  parameter logic [DATA_W-1:0] IDLE_BYTE      = DATA_W'(DEFAULT_IDLE_BYTE),
  parameter int unsigned       GAP_CYCLES     = 4,
  parameter int unsigned       TIMEOUT_CYCLES = 65535,
  parameter int unsigned       CNT_W          = 16
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic              ack_m_q, ack_m_d;
  logic              ack_a_q, ack_a_d;
  logic              owner_q, owner_d;
  logic              byte_done;
  logic              grant_valid;
  logic              grant_id;

`ifdef UART_TX_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES - 1);
  logic tout_q, tout_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
`endif

  tx_arb_rr2 u_rr2 (
    .req_m       (bus.req_m),
    .req_a       (bus.req_a),
    .owner       (owner_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Next-state and next-output logic for the IDLE -> SEND -> GAP sequence.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    tx_d      = tx_q;
    ack_m_d   = 1'b0;
    ack_a_d   = 1'b0;
    owner_d   = owner_q;
    byte_done = 1'b0;
`ifdef UART_TX_TIMEOUT_EN
    tout_d    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (grant_valid) begin
          tx_d    = grant_id ? bus.bits_a : bus.bits_m;
          ack_m_d = (grant_id == OWNER_MANUAL);
          ack_a_d = (grant_id == OWNER_AUTO);
          owner_d = grant_id;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
`ifdef UART_TX_TIMEOUT_EN
        // tx_ready on the limit cycle completes normally rather than aborting.
        tout_d    = !bus.tx_ready && (cnt == TIMEOUT_LIM);
        byte_done = bus.tx_ready || tout_d;
        if (!byte_done) begin
          cnt_d = cnt + CNT_ONE;
        end
`else
        byte_done = bus.tx_ready;
`endif
      end
      GAP: begin
        if (cnt <= CNT_ONE) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (byte_done) begin
      tx_d    = IDLE_BYTE;
      cnt_d   = GAP_LOAD;
      state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
    end
  end

  // State, counter and all outputs are registered; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      tx_q    <= IDLE_BYTE;
      ack_m_q <= 1'b0;
      ack_a_q <= 1'b0;
      owner_q <= OWNER_AUTO;
`ifdef UART_TX_TIMEOUT_EN
      tout_q  <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      tx_q    <= tx_d;
      ack_m_q <= ack_m_d;
      ack_a_q <= ack_a_d;
      owner_q <= owner_d;
`ifdef UART_TX_TIMEOUT_EN
      tout_q  <= tout_d;
`endif
    end
  end

  assign bus.tx_bits = tx_q;
  assign bus.ack_m   = ack_m_q;
  assign bus.ack_a   = ack_a_q;
  assign bus.owner   = owner_q;
  assign bus.busy    = (state != IDLE);
`ifdef UART_TX_TIMEOUT_EN
  assign bus.timeout_err = tout_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
  import genshin_uart_pkg::*;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned GAP     = 4;
  localparam int unsigned TIMEOUT = 16;
  localparam logic [7:0]  IDLE_B  = 8'h00;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.DATA_W(DATA_W)) bus ();

  uart_tx_arbiter #(
    .DATA_W         (DATA_W),
    .IDLE_BYTE      (IDLE_B),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TIMEOUT),
    .CNT_W          (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // reference model: a byte is "in flight" from its grant until tx_ready (or timeout);
  // after that the arbiter is unavailable until GAP edges have passed
  bit         m_in_send;
  bit         m_owner;
  logic [7:0] m_byte;
  int         m_edge;
  int         m_gap_end;
  int         m_grant_edge;
  bit         g_m, g_a;

  logic [7:0] exp_tx;
  logic       exp_busy, exp_ack_m, exp_ack_a, exp_owner, exp_tout;

  logic [8:0] sb_q[$];
  logic [7:0] ack_log[$];
  logic [8:0] sb_e;
  bit         mon_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_in_send = 0;
    m_owner   = 1'b1;
    m_byte    = IDLE_B;
    m_edge    = 0;
    m_gap_end = 0;
    g_m = 0; g_a = 0;
    exp_tx = IDLE_B; exp_busy = 0; exp_ack_m = 0; exp_ack_a = 0;
    exp_owner = 1'b1; exp_tout = 0;
    sb_q.delete();
  endtask

  // predicts the effect of the coming clock edge from the inputs now applied
  task automatic model_step();
    bit src;
    m_edge++;
    exp_ack_m = 0; exp_ack_a = 0; exp_tout = 0;
    g_m = 0; g_a = 0;
    if (m_in_send) begin
      if (bus.tx_ready) begin
        m_in_send = 0;
        m_gap_end = m_edge + int'(GAP);
      end
`ifdef UART_TX_TIMEOUT_EN
      else if (m_edge - m_grant_edge == int'(TIMEOUT)) begin
        m_in_send = 0;
        m_gap_end = m_edge + int'(GAP);
        exp_tout  = 1;
      end
`endif
    end else if (m_edge > m_gap_end && (bus.req_m || bus.req_a)) begin
      src          = (bus.req_m && bus.req_a) ? !m_owner : bus.req_a;
      m_owner      = src;
      m_in_send    = 1;
      m_grant_edge = m_edge;
      m_byte       = src ? bus.bits_a : bus.bits_m;
      exp_ack_m    = !src;
      exp_ack_a    = src;
      g_m          = !src;
      g_a          = src;
      sb_q.push_back({src, m_byte});
    end
    exp_tx    = m_in_send ? m_byte : IDLE_B;
    exp_busy  = m_in_send || (m_edge < m_gap_end);
    exp_owner = m_owner;
  endtask

  // monitor: compares every cycle and retires scoreboard entries on each ack
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && !rst) begin
        check("tx_bits", 32'(bus.tx_bits), 32'(exp_tx));
        check("busy", 32'(bus.busy), 32'(exp_busy));
        check("ack_m", 32'(bus.ack_m), 32'(exp_ack_m));
        check("ack_a", 32'(bus.ack_a), 32'(exp_ack_a));
        check("owner", 32'(bus.owner), 32'(exp_owner));
        check("timeout_err", 32'(bus.timeout_err), 32'(exp_tout));
        if (bus.ack_m || bus.ack_a) begin
          ack_log.push_back(bus.tx_bits);
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL grant_sb actual=unexpected_ack expected=no_ack");
          end else begin
            sb_e = sb_q.pop_front();
            check("grant_sb", 32'({bus.owner, bus.tx_bits}), 32'(sb_e));
          end
        end
      end
    end
  end

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    if (g_m) bus.req_m = 1'b0;
    if (g_a) bus.req_a = 1'b0;
    bus.tx_ready = 1'b0;
  endtask

  task automatic do_reset();
    mon_en = 0;
    bus.req_m = 1'b0; bus.req_a = 1'b0; bus.tx_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_tx_bits", 32'(bus.tx_bits), 32'(IDLE_B));
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ack_m", 32'(bus.ack_m), 32'd0);
    check("rst_ack_a", 32'(bus.ack_a), 32'd0);
    check("rst_owner", 32'(bus.owner), 32'd1);
    check("rst_timeout", 32'(bus.timeout_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    mon_en = 1;
  endtask

  task automatic drain();
    bus.req_m = 1'b0;
    bus.req_a = 1'b0;
    for (int i = 0; i < 200 && (m_in_send || m_edge < m_gap_end); i++) begin
      bus.tx_ready = m_in_send;
      tick();
    end
  endtask

  logic [7:0] exp_seq [3];
  bit         prev_txr;

  initial begin
    exp_seq[0] = 8'h21; exp_seq[1] = 8'h42; exp_seq[2] = 8'h21;
    bus.req_m = 1'b0; bus.req_a = 1'b0; bus.tx_ready = 1'b0;
    bus.bits_m = '0; bus.bits_a = '0;
    model_reset();
    #2;
    do_reset();

    // single manual request
    bus.bits_m = 8'h15; bus.req_m = 1'b1;
    tick();
    check("t1_tx_bits", 32'(bus.tx_bits), 32'h15);
    check("t1_ack_m", 32'(bus.ack_m), 32'd1);
    check("t1_owner", 32'(bus.owner), 32'd0);
    check("t1_busy", 32'(bus.busy), 32'd1);
    tick();
    check("t1_ack_one_cycle", 32'(bus.ack_m), 32'd0);
    tick();

    // completion, gap, and stray tx_ready during the gap
    bus.tx_ready = 1'b1;
    tick();
    check("t2_tx_idle", 32'(bus.tx_bits), 32'(IDLE_B));
    check("t2_busy_gap", 32'(bus.busy), 32'd1);
    tick();
    bus.tx_ready = 1'b1;
    tick();
    tick();
    check("t2_busy_gap_end", 32'(bus.busy), 32'd1);
    tick();
    check("t2_idle_after_gap", 32'(bus.busy), 32'd0);

    // stray tx_ready while idle
    bus.tx_ready = 1'b1;
    tick();
    check("t6_idle_busy", 32'(bus.busy), 32'd0);
    check("t6_idle_tx", 32'(bus.tx_bits), 32'(IDLE_B));

    // tie after a manual grant goes to auto; reset lands mid-SEND
    bus.bits_m = 8'h21; bus.bits_a = 8'h42;
    bus.req_m = 1'b1; bus.req_a = 1'b1;
    tick();
    check("t4_tx_42", 32'(bus.tx_bits), 32'h42);
    check("t4_ack_a", 32'(bus.ack_a), 32'd1);
    tick();
    check("t4_pre_rst_tx", 32'(bus.tx_bits), 32'h42);
    do_reset();

    // held tie alternates manual, auto, manual
    ack_log.delete();
    for (int i = 0; i < 200 && ack_log.size() < 3; i++) begin
      bus.bits_m = 8'h21; bus.bits_a = 8'h42;
      bus.req_m = 1'b1; bus.req_a = 1'b1;
      bus.tx_ready = m_in_send && ($urandom_range(0, 2) == 0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t3_seq%0d", i),
            (ack_log.size() > i) ? 32'(ack_log[i]) : 32'hFFFF_FFFF, 32'(exp_seq[i]));
    end
    drain();

`ifdef UART_TX_TIMEOUT_EN
    // no tx_ready: abort after TIMEOUT edges
    bus.bits_m = 8'h5A; bus.req_m = 1'b1;
    tick();
    repeat (TIMEOUT - 1) tick();
    tick();
    check("t5_timeout_pulse", 32'(bus.timeout_err), 32'd1);
    check("t5_timeout_tx", 32'(bus.tx_bits), 32'(IDLE_B));
    drain();
    // tx_ready on the limit edge wins
    bus.bits_m = 8'hA5; bus.req_m = 1'b1;
    tick();
    repeat (TIMEOUT - 1) tick();
    bus.tx_ready = 1'b1;
    tick();
    check("t5_ready_wins", 32'(bus.timeout_err), 32'd0);
    drain();
`endif

    // randomized traffic
    prev_txr = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!bus.req_m && $urandom_range(0, 3) == 0) begin
        bus.bits_m = 8'($urandom);
        bus.req_m  = 1'b1;
      end
      if (!bus.req_a && $urandom_range(0, 3) == 0) begin
        bus.bits_a = 8'($urandom);
        bus.req_a  = 1'b1;
      end
      bus.tx_ready = !prev_txr && ($urandom_range(0, 3) == 0);
      prev_txr = bus.tx_ready;
      tick();
    end
    drain();
    tick();
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    mon_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
